apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles with PREADY low before abort; 0 disables the timeout.
REQ-002 SHALL have port PCLK, input, 1 bit: clock; all logic on rising edge.
REQ-003 SHALL have port PRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-006 SHALL have ports cmd_write (input, 1 bit, 1 = write), cmd_addr (input, 32 bits) and cmd_wdata (input, 32 bits).
REQ-007 SHALL have ports rsp_valid (output, 1 bit, one-cycle response pulse), rsp_rdata (output, 32 bits), rsp_err (output, 1 bit) and rsp_timeout (output, 1 bit).
REQ-008 SHALL have APB outputs PSEL (1), PENABLE (1), PWRITE (1), PADDR (32) and PWDATA (32).
REQ-009 SHALL have APB inputs PRDATA (32), PREADY (1) and PSLVERR (1).

Function
REQ-010 SHALL implement the states IDLE, SETUP and ACCESS; all outputs SHALL be registered or decoded from state only.
REQ-011 SHALL drive cmd_ready = 1 only in IDLE; a handshake (cmd_valid & cmd_ready) at an edge SHALL latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and move to SETUP.
REQ-012 SHALL, in SETUP, drive PSEL = 1 and PENABLE = 0 for exactly one cycle, then unconditionally move to ACCESS.
REQ-013 SHALL, in ACCESS, drive PSEL = 1 and PENABLE = 1; on an edge with PREADY = 1 it SHALL sample PRDATA and PSLVERR, return to IDLE, and pulse rsp_valid for exactly the next cycle.
REQ-014 SHALL never drive PENABLE = 1 while PSEL = 0; PSEL and PENABLE SHALL be 0 in IDLE.
REQ-015 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP through the last ACCESS cycle, and SHALL keep their last values in IDLE.
REQ-016 SHALL set rsp_err = PSLVERR (sampled only when PREADY = 1) and rsp_timeout = 0 on normal completion.
REQ-017 SHALL set rsp_rdata = the sampled PRDATA for reads (even when PSLVERR = 1), and rsp_rdata = 0 for writes.
REQ-018 SHALL keep rsp_rdata, rsp_err and rsp_timeout at 0 whenever rsp_valid = 0.
REQ-019 SHALL count ACCESS cycles with PREADY = 0 in a 16-bit counter, cleared on entry to SETUP.
REQ-020 SHALL, when TIMEOUT != 0 and the count reaches TIMEOUT, abort: return to IDLE, deassert PSEL/PENABLE, and pulse rsp_valid with rsp_err = 1, rsp_timeout = 1 and rsp_rdata = 0.
REQ-021 SHALL give PREADY = 1 priority over the timeout in the same cycle; completion is normal.
REQ-022 SHALL have a minimum latency of handshake edge k to rsp_valid high in the cycle following edge k+2 (PREADY high in the first ACCESS cycle).
REQ-023 SHALL accept a new command in the same cycle rsp_valid is high (back-to-back); the minimum command period is 3 cycles.
REQ-024 SHALL provide no response backpressure; rsp_valid is a single-cycle pulse per accepted command, never duplicated.

Reset
REQ-025 SHALL, while PRESETn = 0, force state = IDLE and PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the counter to 0.
REQ-026 SHALL take effect asynchronously mid-transfer: PSEL/PENABLE drop immediately, the in-flight command is discarded, and no rsp_valid is produced.
REQ-027 SHALL drive cmd_ready = 1 from the first rising edge after PRESETn deasserts.

Verification
REQ-028 SHALL verify write with zero waits: write 0x0000_0010 / 0xDEADBEEF, PREADY = 1 -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
REQ-029 SHALL verify read with 3 waits: read 0x1000_0004, PREADY low for 3 cycles, then high with PRDATA = 0x12345678 -> PENABLE high 4 cycles, rsp_rdata = 0x12345678, PADDR stable throughout.
REQ-030 SHALL verify slave error: read with PSLVERR = 1 at PREADY -> rsp_err = 1, rsp_timeout = 0; PSLVERR = 1 while PREADY = 0 is ignored.
REQ-031 SHALL verify timeout: TIMEOUT = 4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err = 1, rsp_timeout = 1, PSEL = 0 next cycle; PREADY rising on the 4th cycle -> normal completion.
REQ-032 SHALL verify back-to-back: cmd_valid held high for 3 commands with PREADY = 1 -> responses every 3 cycles, cmd_ready never high outside IDLE.
REQ-033 SHALL verify reset mid-ACCESS: PRESETn low -> PSEL = 0 immediately, no rsp_valid; after release, cmd_ready = 1 and the next command completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// apb_cmd_master: one-command-at-a-time bridge from a valid/ready request port to an APB master,
// with a wait-state timeout that aborts a stuck ACCESS phase. Rev 1.0
module apb_cmd_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [16:0] C_TMO_LIMIT = 17'(TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_to_q, rsp_to_d;
  logic        expired;

  // This wait cycle would bring the count up to the limit.
  assign expired = (C_TMO_LIMIT != 17'd0) && (({1'b0, cnt_q} + 17'd1) >= C_TMO_LIMIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          cnt_d    = 16'd0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
        end else begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (expired) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus strobes and ready are registered copies of the next state.
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
    ready_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      paddr_q     <= 32'd0;
      pwdata_q    <= 32'd0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// tb_apb_cmd_master: directed vectors for apb_cmd_master built with TIMEOUT = 4.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(.TIMEOUT(4)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One command; waits = ACCESS cycles with PREADY low before it rises (large value = never).
  task automatic run_cmd(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] prdata,
                         input logic slverr, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_to, input int exp_acc);
    int acc;
    bit done;
    @(negedge PCLK);
    check({name, ":idle_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0;
    check({name, ":setup_psel"}, 32'(PSEL), 32'd1);
    check({name, ":setup_penable"}, 32'(PENABLE), 32'd0);
    check({name, ":setup_ready"}, 32'(cmd_ready), 32'd0);
    check({name, ":paddr"}, PADDR, addr);
    check({name, ":pwrite"}, 32'(PWRITE), 32'(wr));
    check({name, ":pwdata"}, PWDATA, wdata);
    acc  = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      if (PSEL) begin
        acc++;
        check({name, ":acc_penable"}, 32'(PENABLE), 32'd1);
        check({name, ":acc_paddr"}, PADDR, addr);
        check({name, ":acc_no_rsp"}, 32'(rsp_valid), 32'd0);
        PREADY  = (i == waits);
        PRDATA  = (i == waits) ? prdata : 32'hBAD0_0000;
        PSLVERR = (i == waits) ? slverr : 1'b1;
      end else begin
        done = 1'b1;
      end
    end
    check({name, ":finished"}, 32'(done), 32'd1);
    check({name, ":access_cycles"}, 32'(acc), 32'(exp_acc));
    check({name, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({name, ":rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
    check({name, ":rsp_rdata"}, rsp_rdata, exp_rdata);
    check({name, ":rsp_penable"}, 32'(PENABLE), 32'd0);
    check({name, ":rsp_ready"}, 32'(cmd_ready), 32'd1);
    check({name, ":paddr_kept"}, PADDR, addr);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h5555_AAAA;
    @(negedge PCLK);
    check({name, ":rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
    check({name, ":rdata_zero"}, rsp_rdata, 32'd0);
    check({name, ":err_zero"}, 32'({rsp_err, rsp_timeout}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  logic [31:0] b2b_addr [3];
  int issued, nrsp, last;

  initial begin
    b2b_addr[0] = 32'h0000_0100;
    b2b_addr[1] = 32'h0000_0204;
    b2b_addr[2] = 32'h0000_0308;

    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst:psel", 32'(PSEL), 32'd0);
    check("rst:penable", 32'(PENABLE), 32'd0);
    check("rst:paddr", PADDR, 32'd0);
    check("rst:cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst:rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    PRESETn = 1'b1;
    #1 check("rst:ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge PCLK);
    check("rst:ready_after_edge", 32'(cmd_ready), 32'd1);

    run_cmd("wr0", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hCAFE_F00D, 1'b0,
            32'd0, 1'b0, 1'b0, 1);
    run_cmd("rd3", 1'b0, 32'h1000_0004, 32'h0, 3, 32'h1234_5678, 1'b0,
            32'h1234_5678, 1'b0, 1'b0, 4);
    run_cmd("rderr", 1'b0, 32'h1000_0008, 32'h0, 1, 32'hA5A5_A5A5, 1'b1,
            32'hA5A5_A5A5, 1'b1, 1'b0, 2);
    run_cmd("wrerr", 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 0, 32'h7777_7777, 1'b1,
            32'd0, 1'b1, 1'b0, 1);
    run_cmd("tmo", 1'b0, 32'h4000_0000, 32'h0, 99, 32'hFFFF_0000, 1'b0,
            32'd0, 1'b1, 1'b1, 4);
    run_cmd("tmo_edge", 1'b0, 32'h4000_0010, 32'h0, 3, 32'h0F0F_1234, 1'b0,
            32'h0F0F_1234, 1'b0, 1'b0, 4);

    // Back-to-back reads with cmd_valid held high
    issued = 0;
    nrsp   = 0;
    last   = -1;
    PREADY = 1'b1;
    PSLVERR = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge PCLK);
      check("b2b:ready_only_idle", 32'(cmd_ready), 32'(!PSEL));
      if (PSEL && PENABLE) PRDATA = ~PADDR;
      if (rsp_valid) begin
        if (nrsp < 3) begin
          check("b2b:rdata", rsp_rdata, ~b2b_addr[nrsp]);
          if (nrsp > 0) check("b2b:period", 32'(c - last), 32'd3);
        end else begin
          check("b2b:extra_rsp", 32'(rsp_valid), 32'd0);
        end
        last = c;
        nrsp++;
      end
      if (cmd_ready) begin
        if (issued < 3) begin
          cmd_valid = 1'b1;
          cmd_write = 1'b0;
          cmd_addr  = b2b_addr[issued];
          issued++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    check("b2b:rsp_count", 32'(nrsp), 32'd3);
    PREADY = 1'b0;
    cmd_valid = 1'b0;

    // Asynchronous reset in the middle of ACCESS
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h2000_0000;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("arst:in_access", 32'({PSEL, PENABLE}), 32'd3);
    #2 PRESETn = 1'b0;
    #1;
    check("arst:psel_drop", 32'(PSEL), 32'd0);
    check("arst:penable_drop", 32'(PENABLE), 32'd0);
    check("arst:ready_low", 32'(cmd_ready), 32'd0);
    check("arst:paddr_clr", PADDR, 32'd0);
    PREADY = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      check("arst:no_rsp", 32'(rsp_valid), 32'd0);
    end
    PREADY = 1'b0;
    PRESETn = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      check("arst:no_rsp_after", 32'(rsp_valid), 32'd0);
      check("arst:idle_after", 32'(PSEL), 32'd0);
    end
    run_cmd("post_rst", 1'b0, 32'h2000_0040, 32'h0, 0, 32'h600D_600D, 1'b0,
            32'h600D_600D, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
